// File: rtl/axi_mctp_pkg.sv
// Shared types and constants for the AXI MCTP write generator.
// SOM/EOM encodings, FSM state enum and header field offsets.
package axi_mctp_pkg;

    localparam logic [1:0] SOM_EOM_S  = 2'b10;
    localparam logic [1:0] SOM_EOM_M  = 2'b00;
    localparam logic [1:0] SOM_EOM_L  = 2'b01;
    localparam logic [1:0] SOM_EOM_SG = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_WHDR,
        ST_WPAY,
        ST_DRAIN
    } state_t;

    localparam int HDR_LEN_LSB = 24;
    localparam int HDR_TAG_LSB = 120;
    localparam int HDR_SEQ_LSB = 124;
    localparam int HDR_SOM_LSB = 126;

    function automatic logic [1:0] som_eom(input logic first, input logic last);
        logic [1:0] r;
        if (first && last)
            r = SOM_EOM_SG;
        else if (first)
            r = SOM_EOM_S;
        else if (last)
            r = SOM_EOM_L;
        else
            r = SOM_EOM_M;
        return r;
    endfunction

endpackage

// File: rtl/axi_mctp_hdr_build.sv
// Combinational 128-bit MCTP packet header former.
// Length byte in the template is replaced by the packet's dword count.
module axi_mctp_hdr_build
    import axi_mctp_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic [1:0]   i_som_eom,
    input  logic [1:0]   i_seq,
    input  logic [3:0]   i_tag,
    input  logic [119:0] i_hdr,
    input  logic [7:0]   i_pay,
    output logic [127:0] o_hdr
);

    logic [31:0] w_len;

    always_comb begin
        w_len = 32'(i_pay) * 32'(DATA_W / 32);
        o_hdr = '0;
        o_hdr[HDR_SOM_LSB +: 2] = i_som_eom;
        o_hdr[HDR_SEQ_LSB +: 2] = i_seq;
        o_hdr[HDR_TAG_LSB +: 4] = i_tag;
        o_hdr[119:0] = i_hdr;
        o_hdr[HDR_LEN_LSB +: 8] = w_len[7:0];
    end

endmodule

// File: rtl/axi_mctp_write_gen.sv
// Splits an MCTP message into AXI write bursts (header beat + payload).
// Optional counters enabled by defining AXI_WGEN_STATS_EN.
module axi_mctp_write_gen
    import axi_mctp_pkg::*;
#(
    parameter int DATA_W        = 256,
    parameter int ADDR_W        = 64,
    parameter int ID_W          = 7,
    parameter int MAX_PAY_BEATS = 3,
    parameter int MAX_OUTST     = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [15:0]         i_cmd_beats,
    input  logic [3:0]          i_cmd_tag,
    input  logic [119:0]        i_cmd_hdr,
    input  logic                i_pl_valid,
    output logic                o_pl_ready,
    input  logic [DATA_W-1:0]   i_pl_data,
    output logic                O_AWVALID,
    input  logic                I_AWREADY,
    output logic [ADDR_W-1:0]   O_AWADDR,
    output logic [7:0]          O_AWLEN,
    output logic [2:0]          O_AWSIZE,
    output logic [1:0]          O_AWBURST,
    output logic [ID_W-1:0]     O_AWID,
    output logic [63:0]         O_AWUSER,
    output logic                O_AWLOCK,
    output logic [3:0]          O_AWCACHE,
    output logic [2:0]          O_AWPROT,
    output logic                O_WVALID,
    input  logic                I_WREADY,
    output logic [DATA_W-1:0]   O_WDATA,
    output logic [DATA_W/8-1:0] O_WSTRB,
    output logic                O_WLAST,
    output logic [15:0]         O_WUSER,
    input  logic                I_BVALID,
    output logic                O_BREADY,
    input  logic [ID_W-1:0]     I_BID,
    input  logic [1:0]          I_BRESP,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
`ifdef AXI_WGEN_STATS_EN
    ,
    output logic [31:0]         o_pkt_cnt,
    output logic [15:0]         o_berr_cnt
`endif
);

    localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_W / 8));

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_tag;
    logic [119:0]      r_hdr;
    logic [15:0]       r_rem;
    logic              r_first;
    logic [1:0]        r_seq;
    logic [7:0]        r_beat;
    logic [3:0]        r_outst;
    logic              r_err;

    logic [7:0]   w_pay;
    logic         w_last_pkt;
    logic         w_beat_last;
    logic         w_aw_ok;
    logic         w_cmd_hs;
    logic         w_aw_hs;
    logic         w_w_hs;
    logic         w_b_hs;
    logic [127:0] w_hdr;
    logic         w_unused;

    assign w_unused = ^I_BID;

    // r_rem counts payload beats still to send, current packet included
    assign w_last_pkt  = (r_rem <= 16'(MAX_PAY_BEATS));
    assign w_pay       = w_last_pkt ? r_rem[7:0] : 8'(MAX_PAY_BEATS);
    assign w_beat_last = (r_beat == w_pay - 8'd1);
    assign w_aw_ok     = (r_outst < 4'(MAX_OUTST));
    assign w_cmd_hs    = i_cmd_valid & o_cmd_ready;
    assign w_aw_hs     = O_AWVALID & I_AWREADY;
    assign w_w_hs      = O_WVALID & I_WREADY;
    assign w_b_hs      = I_BVALID & O_BREADY;

    axi_mctp_hdr_build #(
        .DATA_W(DATA_W)
    ) u_hdr (
        .i_som_eom(som_eom(r_first, w_last_pkt)),
        .i_seq    (r_seq),
        .i_tag    (r_tag),
        .i_hdr    (r_hdr),
        .i_pay    (w_pay),
        .o_hdr    (w_hdr)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_cmd_hs) w_next = ST_AW;
            ST_AW:    if (w_aw_hs) w_next = ST_WHDR;
            ST_WHDR:  if (w_w_hs) w_next = ST_WPAY;
            ST_WPAY: begin
                if (w_w_hs && w_beat_last)
                    w_next = w_last_pkt ? ST_DRAIN : ST_AW;
            end
            ST_DRAIN: if (r_outst == 4'd0) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = 1'b0;
        o_pl_ready  = 1'b0;
        O_AWVALID   = 1'b0;
        O_AWADDR    = '0;
        O_AWLEN     = '0;
        O_AWSIZE    = '0;
        O_AWBURST   = '0;
        O_WVALID    = 1'b0;
        O_WDATA     = '0;
        O_WSTRB     = '0;
        O_WLAST     = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: o_cmd_ready = 1'b1;
            ST_AW: begin
                O_AWVALID = w_aw_ok;
                O_AWADDR  = r_addr;
                O_AWLEN   = w_pay;
                O_AWSIZE  = AW_SIZE;
                O_AWBURST = 2'b01;
            end
            ST_WHDR: begin
                O_WVALID       = 1'b1;
                O_WDATA[127:0] = w_hdr;
                O_WSTRB        = '1;
            end
            ST_WPAY: begin
                O_WVALID   = i_pl_valid;
                O_WDATA    = i_pl_data;
                O_WSTRB    = '1;
                O_WLAST    = w_beat_last;
                o_pl_ready = I_WREADY;
            end
            ST_DRAIN: o_done = (r_outst == 4'd0);
            default: ;
        endcase
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign O_BREADY  = (r_outst != 4'd0);
    assign o_err     = r_err;
    assign O_AWID    = '0;
    assign O_AWUSER  = '0;
    assign O_AWLOCK  = 1'b0;
    assign O_AWCACHE = '0;
    assign O_AWPROT  = '0;
    assign O_WUSER   = '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_tag   <= '0;
            r_hdr   <= '0;
            r_rem   <= '0;
            r_first <= 1'b0;
            r_seq   <= '0;
            r_beat  <= '0;
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_addr  <= i_cmd_addr;
                r_tag   <= i_cmd_tag;
                r_hdr   <= i_cmd_hdr;
                r_rem   <= (i_cmd_beats == 16'd0) ? 16'd1 : i_cmd_beats;
                r_first <= 1'b1;
                r_seq   <= '0;
                r_beat  <= '0;
            end
            if (r_state == ST_WPAY && w_w_hs) begin
                if (w_beat_last) begin
                    r_beat  <= '0;
                    r_rem   <= r_rem - 16'(w_pay);
                    r_first <= 1'b0;
                    r_seq   <= r_seq + 2'd1;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
            if (w_aw_hs && !w_b_hs)
                r_outst <= r_outst + 4'd1;
            else if (!w_aw_hs && w_b_hs)
                r_outst <= r_outst - 4'd1;
            if (w_b_hs && I_BRESP != 2'b00)
                r_err <= 1'b1;
        end
    end

`ifdef AXI_WGEN_STATS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pkt_cnt  <= '0;
            o_berr_cnt <= '0;
        end else if (w_b_hs) begin
            if (o_pkt_cnt != '1)
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            if (I_BRESP != 2'b00 && o_berr_cnt != '1)
                o_berr_cnt <= o_berr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_mctp_write_gen.sv
// Randomized self-checking bench for axi_mctp_write_gen.
// Expected bursts are derived from message length rules, not RTL state.
module tb_axi_mctp_write_gen;

    localparam int DW  = 256;
    localparam int AW  = 64;
    localparam int IW  = 7;
    localparam int MPB = 3;
    localparam int MO  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_reset;
    logic i_cmd_valid, o_cmd_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [15:0] i_cmd_beats;
    logic [3:0] i_cmd_tag;
    logic [119:0] i_cmd_hdr;
    logic i_pl_valid, o_pl_ready;
    logic [DW-1:0] i_pl_data;
    logic O_AWVALID, I_AWREADY;
    logic [AW-1:0] O_AWADDR;
    logic [7:0] O_AWLEN;
    logic [2:0] O_AWSIZE;
    logic [1:0] O_AWBURST;
    logic [IW-1:0] O_AWID;
    logic [63:0] O_AWUSER;
    logic O_AWLOCK;
    logic [3:0] O_AWCACHE;
    logic [2:0] O_AWPROT;
    logic O_WVALID, I_WREADY;
    logic [DW-1:0] O_WDATA;
    logic [DW/8-1:0] O_WSTRB;
    logic O_WLAST;
    logic [15:0] O_WUSER;
    logic I_BVALID, O_BREADY;
    logic [IW-1:0] I_BID;
    logic [1:0] I_BRESP;
    logic o_busy, o_done, o_err;
`ifdef AXI_WGEN_STATS_EN
    logic [31:0] o_pkt_cnt;
    logic [15:0] o_berr_cnt;
`endif

    axi_mctp_write_gen #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW),
        .MAX_PAY_BEATS(MPB), .MAX_OUTST(MO)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_beats(i_cmd_beats),
        .i_cmd_tag(i_cmd_tag), .i_cmd_hdr(i_cmd_hdr),
        .i_pl_valid(i_pl_valid), .o_pl_ready(o_pl_ready),
        .i_pl_data(i_pl_data),
        .O_AWVALID(O_AWVALID), .I_AWREADY(I_AWREADY),
        .O_AWADDR(O_AWADDR), .O_AWLEN(O_AWLEN),
        .O_AWSIZE(O_AWSIZE), .O_AWBURST(O_AWBURST),
        .O_AWID(O_AWID), .O_AWUSER(O_AWUSER),
        .O_AWLOCK(O_AWLOCK), .O_AWCACHE(O_AWCACHE),
        .O_AWPROT(O_AWPROT),
        .O_WVALID(O_WVALID), .I_WREADY(I_WREADY),
        .O_WDATA(O_WDATA), .O_WSTRB(O_WSTRB),
        .O_WLAST(O_WLAST), .O_WUSER(O_WUSER),
        .I_BVALID(I_BVALID), .O_BREADY(O_BREADY),
        .I_BID(I_BID), .I_BRESP(I_BRESP),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef AXI_WGEN_STATS_EN
        , .o_pkt_cnt(o_pkt_cnt), .o_berr_cnt(o_berr_cnt)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
    } aw_t;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } w_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit wrand = 0;
    int bdelay = 2;
    int err_pkt = -1;
    int bnum = 0;
    int outst = 0;
    int viol = 0;
    int done_cnt = 0;
    int bready_err = 0;
    int pkts_since_rst = 0;
    aw_t awq[$];
    w_t wq[$];
    int bdue[$];
    logic [DW-1:0] sentq[$];

    // Bus monitor plus B-channel responder with programmable latency
    always @(posedge clk) begin
        cyc++;
        if (i_reset) begin
            bdue.delete();
            outst = 0;
            pkts_since_rst = 0;
        end else begin
            if (O_BREADY !== (outst > 0)) bready_err++;
            if (O_AWVALID && outst >= MO) viol++;
            if (I_BVALID && O_BREADY) begin
                void'(bdue.pop_front());
                bnum++;
                outst--;
                pkts_since_rst++;
            end
            if (O_AWVALID && I_AWREADY) begin
                awq.push_back('{O_AWADDR, O_AWLEN, O_AWSIZE, O_AWBURST, O_AWID});
                bdue.push_back(cyc + bdelay);
                outst++;
            end
            if (O_WVALID && I_WREADY)
                wq.push_back('{O_WDATA, O_WSTRB, O_WLAST});
            if (o_done) done_cnt++;
        end
        #1;
        I_BVALID = (bdue.size() > 0) ? (cyc >= bdue[0]) : 1'b0;
        I_BRESP = (I_BVALID && bnum == err_pkt) ? 2'b10 : 2'b00;
        I_WREADY = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
        I_AWREADY = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic issue_cmd(input logic [AW-1:0] a, input int beats,
                             input logic [3:0] tg, input logic [119:0] h);
        bit ok = 0;
        i_cmd_addr = a;
        i_cmd_beats = 16'(beats);
        i_cmd_tag = tg;
        i_cmd_hdr = h;
        i_cmd_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge clk);
            if (o_cmd_ready) ok = 1;
            #1;
        end
        i_cmd_valid = 1'b0;
        i_cmd_addr = {$urandom, $urandom};
        i_cmd_beats = 16'($urandom_range(1, 40));
        i_cmd_tag = 4'($urandom);
        i_cmd_hdr = {$urandom, $urandom, $urandom, 24'($urandom)};
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: ready=%0b required 1", o_cmd_ready);
        end
    endtask

    task automatic feed(input int n, input bit prand);
        int guard = 0;
        for (int b = 0; b < n; b++) begin
            logic [DW-1:0] d;
            bit sent = 0;
            d = rand_word();
            i_pl_data = d;
            while (!sent && guard < 5000) begin
                if (!i_pl_valid)
                    i_pl_valid = prand ? 1'($urandom_range(0, 1)) : 1'b1;
                @(posedge clk);
                guard++;
                if (i_pl_valid && o_pl_ready) sent = 1;
                #1;
            end
            if (sent) sentq.push_back(d);
        end
        i_pl_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk);
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s done_timeout: done_cnt=%0d required 1", name, done_cnt);
        end
    endtask

    task automatic run_msg(input int beats, input int bd, input bit rnd,
                           input int errp, input string name);
        logic [AW-1:0] addr;
        logic [3:0] tag;
        logic [127:0] tmp;
        logic [119:0] hdr;
        int eff, npk, rem, wi, si, awbad, hbad, pbad;
        string first_aw, first_h, first_p;
        awq.delete();
        wq.delete();
        sentq.delete();
        done_cnt = 0;
        bnum = 0;
        bdelay = bd;
        wrand = rnd;
        err_pkt = errp;
        addr = {$urandom, $urandom};
        tag = 4'($urandom);
        tmp = rand_word()[127:0];
        hdr = tmp[119:0];
        eff = (beats == 0) ? 1 : beats;
        npk = (eff + MPB - 1) / MPB;
        issue_cmd(addr, beats, tag, hdr);
        fork
            feed(eff, rnd);
            wait_done(name);
        join
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        total++;
        if (awq.size() !== npk) begin
            bad++;
            $display("FAIL %s aw_count: got %0d required %0d", name, awq.size(), npk);
        end
        total++;
        if (wq.size() !== npk + eff) begin
            bad++;
            $display("FAIL %s w_count: got %0d required %0d", name, wq.size(), npk + eff);
        end
        rem = eff; wi = 0; si = 0; awbad = 0; hbad = 0; pbad = 0;
        for (int k = 0; k < npk; k++) begin
            int p;
            logic [1:0] se;
            logic [119:0] h;
            logic [DW-1:0] eh;
            p = (rem < MPB) ? rem : MPB;
            if (k < awq.size()) begin
                if (awq[k].addr !== addr || awq[k].len !== 8'(p) ||
                    awq[k].size !== 3'd5 || awq[k].burst !== 2'b01 ||
                    awq[k].id !== '0) begin
                    if (awbad == 0)
                        first_aw = $sformatf("pkt%0d addr=%h len=%0d size=%0d burst=%0d required addr=%h len=%0d size=5 burst=1",
                            k, awq[k].addr, awq[k].len, awq[k].size, awq[k].burst, addr, p);
                    awbad++;
                end
            end
            if (npk == 1) se = 2'b11;
            else if (k == 0) se = 2'b10;
            else if (k == npk - 1) se = 2'b01;
            else se = 2'b00;
            h = hdr;
            h[31:24] = 8'(p * DW / 32);
            eh = '0;
            eh[127:0] = {se, 2'(k % 4), tag, h};
            if (wi < wq.size()) begin
                if (wq[wi].data !== eh || wq[wi].last !== 1'b0 || wq[wi].strb !== '1) begin
                    if (hbad == 0)
                        first_h = $sformatf("pkt%0d hdr=%h last=%0b required %h last=0",
                            k, wq[wi].data[127:0], wq[wi].last, eh[127:0]);
                    hbad++;
                end
            end
            wi++;
            for (int j = 0; j < p; j++) begin
                if (wi < wq.size() && si < sentq.size()) begin
                    if (wq[wi].data !== sentq[si] || wq[wi].last !== (j == p - 1) ||
                        wq[wi].strb !== '1) begin
                        if (pbad == 0)
                            first_p = $sformatf("pkt%0d beat%0d data[63:0]=%h last=%0b required %h last=%0b",
                                k, j, wq[wi].data[63:0], wq[wi].last, sentq[si][63:0], (j == p - 1));
                        pbad++;
                    end
                end
                wi++;
                si++;
            end
            rem -= p;
        end
        total++;
        if (awbad != 0) begin
            bad++;
            $display("FAIL %s aw_fields: %s", name, first_aw);
        end
        total++;
        if (hbad != 0) begin
            bad++;
            $display("FAIL %s header: %s", name, first_h);
        end
        total++;
        if (pbad != 0) begin
            bad++;
            $display("FAIL %s payload: %s", name, first_p);
        end
        wrand = 0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({O_AWVALID, O_WVALID, O_BREADY, o_busy, o_done, o_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_in: aw=%0b w=%0b b=%0b busy=%0b done=%0b err=%0b required 0",
                O_AWVALID, O_WVALID, O_BREADY, o_busy, o_done, o_err);
        end
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (o_cmd_ready !== 1'b1 || O_WDATA !== '0 || O_AWADDR !== '0) begin
            bad++;
            $display("FAIL reset_out: cmd_ready=%0b wdata_nz=%0b awaddr=%h required 1 0 0",
                o_cmd_ready, |O_WDATA, O_AWADDR);
        end
    endtask

    task automatic test_multi_pkt();
        run_msg(9, 2, 0, -1, "multi9");
    endtask

    task automatic test_single();
        run_msg(2, 2, 0, -1, "single2");
        total++;
        if (wq.size() == 0 || wq[0].data[31:24] !== 8'h10 || wq[0].data[127:126] !== 2'b11) begin
            bad++;
            $display("FAIL single_len: len=%h som=%b required 10 11",
                (wq.size() > 0) ? wq[0].data[31:24] : 8'hxx,
                (wq.size() > 0) ? wq[0].data[127:126] : 2'bxx);
        end
    endtask

    task automatic test_outstanding();
        viol = 0;
        run_msg(20, 50, 0, -1, "outst20");
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL outst_limit: awvalid_at_max=%0d required 0", viol);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++)
            run_msg((i == 0) ? 0 : int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 8)), 1, -1, $sformatf("rand%0d", i));
    endtask

    task automatic test_berr();
        run_msg(9, 4, 0, 1, "berr");
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (o_err !== 1'b1) begin
            bad++;
            $display("FAIL berr_sticky: o_err=%0b required 1", o_err);
        end
`ifdef AXI_WGEN_STATS_EN
        total++;
        if (o_berr_cnt !== 16'd1 || o_pkt_cnt !== 32'(pkts_since_rst)) begin
            bad++;
            $display("FAIL stats: berr=%0d pkt=%0d required 1 %0d",
                o_berr_cnt, o_pkt_cnt, pkts_since_rst);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        bdelay = 40;
        err_pkt = -1;
        issue_cmd({$urandom, $urandom}, 6, 4'h3, 120'h0);
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk);
            if (o_pl_ready) hit = 1;
        end
        #1;
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL mid_reach_wpay: pl_ready=%0b required 1", o_pl_ready);
        end
        i_pl_data = rand_word();
        i_pl_valid = 1'b1;
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({O_AWVALID, O_WVALID, O_WLAST, O_BREADY, o_busy, o_done, o_err, o_pl_ready} !== 8'b0 ||
            O_WDATA !== '0 || O_AWADDR !== '0) begin
            bad++;
            $display("FAIL mid_reset: aw=%0b w=%0b last=%0b b=%0b busy=%0b err=%0b wdata_nz=%0b required all 0",
                O_AWVALID, O_WVALID, O_WLAST, O_BREADY, o_busy, o_err, |O_WDATA);
        end
        i_pl_valid = 1'b0;
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        run_msg(5, 2, 0, -1, "after_reset");
    endtask

    initial begin
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_addr = '0;
        i_cmd_beats = '0;
        i_cmd_tag = '0;
        i_cmd_hdr = '0;
        i_pl_valid = 1'b0;
        i_pl_data = '0;
        I_AWREADY = 1'b1;
        I_WREADY = 1'b1;
        I_BVALID = 1'b0;
        I_BID = '0;
        I_BRESP = 2'b00;
        test_reset();
        test_multi_pkt();
        test_single();
        test_outstanding();
        test_random();
        test_berr();
        test_reset_mid();
        total++;
        if (bready_err !== 0) begin
            bad++;
            $display("FAIL bready: wrong_cycles=%0d required 0", bready_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mctp_write_gen.md
AXI_MCTP_WRITE_GEN -- requirements
Module: axi_mctp_write_gen

Interface
REQ-001 Parameters SHALL be: DATA_W, default 256, AXI data width (multiple of 128, >=256); ADDR_W, default 64; ID_W, default 7; MAX_PAY_BEATS, default 3, payload beats per packet (1..255); MAX_OUTST, default 4, outstanding writes (1..15).
REQ-002 i_clk  in  1  sole clock, all logic rising-edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_cmd_valid/o_cmd_ready  in/out  1/1  message command handshake.
REQ-005 i_cmd_addr  in  ADDR_W  target address, used by every packet of the message.
REQ-006 i_cmd_beats  in  16  total payload beats (0 is illegal and treated as 1).
REQ-007 i_cmd_tag  in  4  MCTP TO bit plus msg tag; i_cmd_hdr  in  120  VDM header template bits [119:0].
REQ-008 i_pl_valid/o_pl_ready/i_pl_data  in/out/in  1/1/DATA_W  payload stream.
REQ-009 O_AWVALID/I_AWREADY, O_AWADDR ADDR_W, O_AWLEN 8, O_AWSIZE 3, O_AWBURST 2, O_AWID ID_W  AXI write address.
REQ-010 O_WVALID/I_WREADY, O_WDATA DATA_W, O_WSTRB DATA_W/8, O_WLAST 1  AXI write data.
REQ-011 I_BVALID/O_BREADY, I_BID ID_W, I_BRESP 2  AXI write response.
REQ-012 O_AWUSER 64, O_AWLOCK, O_AWCACHE 4, O_AWPROT 3, O_WUSER 16  out, constant 0.
REQ-013 o_busy 1 (command accepted, not done); o_done 1 (one-cycle pulse); o_err 1 (sticky).

Function
REQ-014 Message SHALL split into N=ceil(beats/MAX_PAY_BEATS) packets; last packet carries remainder.
REQ-015 Packet SHALL be 1 header beat plus P payload beats: AWLEN=P, AWSIZE=log2(DATA_W/8), AWBURST=INCR, AWID=0, WSTRB all ones.
REQ-016 Header beat: O_WDATA[127:0]={SOM_EOM, seq, tag, hdr'}; upper bits 0; hdr' = i_cmd_hdr with [31:24] = P*DATA_W/32 modulo 256.
REQ-017 SOM_EOM: N=1 -> 2'b11; first -> 2'b10; middle -> 2'b00; last -> 2'b01.
REQ-018 seq SHALL be 0 on first packet of each message, +1 per packet, wrapping 3->0.
REQ-019 FSM states IDLE, AW, WHDR, WPAY, DRAIN: IDLE->AW on cmd accept (o_cmd_ready=1 only in IDLE); AW->WHDR on AW handshake; WHDR->WPAY on W handshake; WPAY->AW after WLAST handshake if packets remain, else DRAIN; DRAIN->IDLE when outstanding=0, with o_done pulse that cycle.
REQ-020 AW SHALL NOT assert while outstanding==MAX_OUTST; outstanding +1 on AW handshake, -1 on B handshake, both same cycle -> unchanged.
REQ-021 O_BREADY SHALL be 1 whenever outstanding>0; BRESP!=0 sets o_err until reset.
REQ-022 o_pl_ready = I_WREADY in WPAY only; O_WVALID in WPAY = i_pl_valid; O_WDATA = i_pl_data (combinational pass-through).
REQ-023 VALID, once high, SHALL hold with stable payload until READY.
REQ-024 Cmd fields SHALL be registered at acceptance; later changes ignored.

Reset
REQ-025 On i_reset: FSM=IDLE, counters 0, all VALID/LAST/BREADY/o_busy/o_done/o_err 0, data/address outputs 0; reset mid-burst abandons the transfer without completion.

Configuration
REQ-026 With AXI_WGEN_STATS_EN defined: ports o_pkt_cnt 32 and o_berr_cnt 16, counting completed B handshakes and error responses, saturating, reset 0; without it the ports and counters SHALL NOT exist.

Structure
REQ-027 Package axi_mctp_pkg SHALL hold SOM_EOM encodings (S=10, M=00, L=01, SG=11), FSM state enum, and header field offsets.
REQ-028 Sub-module axi_mctp_hdr_build SHALL form the 128-bit header combinationally; all else in the top.

Verification
REQ-029 beats=9, MAX_PAY_BEATS=3, ready always 1 -> 3 bursts AWLEN=3, SOM_EOM 10/00/01, seq 0/1/2, o_done one pulse.
REQ-030 beats=2 -> single burst AWLEN=2, SOM_EOM=11, seq=0, length byte=0x10.
REQ-031 beats=20, MAX_OUTST=2, BVALID delayed 50 cycles -> AWVALID never with 2 outstanding, 7 packets, seq wraps 3->0.
REQ-032 I_WREADY/i_pl_valid random 50% -> O_WDATA matches payload order, WLAST only on beat P.
REQ-033 Second packet BRESP=2'b10 -> o_err=1 stays, message still completes; stats build shows o_berr_cnt=1.
REQ-034 i_reset asserted during WPAY -> all outputs 0 next edge, new command after release sent correctly.
